// File: rtl/fmac_ipcs_fifo_wr_arb_if.sv
// Packet source link into the IPCS FIFO write arbiter: request, length, data beat and handshake.
// Latency: none (wires only).
// Backpressure: rdy gates each data word; rej pulses when a request is refused.
interface fmac_ipcs_fifo_wr_arb_if #(
    parameter int WIDTH = 64,
    parameter int PTR   = 9
);
    logic             req;
    logic [PTR:0]     len;
    logic             vld;
    logic [WIDTH-1:0] data;
    logic             eop;
    logic             rdy;
    logic             rej;

    modport master (output req, len, vld, data, eop, input rdy, rej);
    modport slave  (input req, len, vld, data, eop, output rdy, rej);
endinterface

// File: rtl/fmac_ipcs_fifo_wr_arb.sv
// Packet-atomic round-robin arbiter sharing the IPCS data FIFO write port between two sources.
// Latency: grant one cycle after req sampled in IDLE; accepted word reaches the FIFO one cycle later.
// Backpressure: a packet is granted only when the FIFO has room for all of it; waiting sources keep req high.
module fmac_ipcs_fifo_wr_arb #(
    parameter int WIDTH   = 64,
    parameter int PTR     = 9,
    parameter int MAX_LEN = 256,
    parameter int SETTLE  = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    fmac_ipcs_fifo_wr_arb_if.slave rq0,
    fmac_ipcs_fifo_wr_arb_if.slave rq1,
    input  logic [PTR:0]           fifo_wrusedw,
    input  logic                   fifo_wrfull,
    output logic                   fifo_wrreq,
    output logic [WIDTH-1:0]       fifo_data,
    output logic [1:0]             grant,
    output logic                   len_err,
    output logic                   ovf_err,
    output logic [15:0]            pkt_cnt0,
    output logic [15:0]            pkt_cnt1
);
    localparam int DEPTH = 2 ** PTR;
    localparam int SW    = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_XFER, ST_SETTLE} state_t;

    state_t          state;
    logic [PTR:0]    cnt;
    logic [SW-1:0]   scnt;
    logic            last_grant;   // 0: rq0 won last, 1: rq1 won last
    logic            rej0;
    logic            rej1;

    logic [PTR+1:0]  space;
    logic            legal0;
    logic            legal1;
    logic            elig0;
    logic            elig1;
    logic            acc;
    logic [WIDTH-1:0] sel_data;
    logic            sel_eop;

    // Free FIFO room computed one bit wider so a full FIFO never wraps to a large value.
    assign space  = (PTR+2)'(DEPTH) - {1'b0, fifo_wrusedw};
    assign legal0 = (rq0.len != '0) && ({1'b0, rq0.len} <= (PTR+2)'(MAX_LEN));
    assign legal1 = (rq1.len != '0) && ({1'b0, rq1.len} <= (PTR+2)'(MAX_LEN));
    assign elig0  = rq0.req && legal0 && ({1'b0, rq0.len} <= space);
    assign elig1  = rq1.req && legal1 && ({1'b0, rq1.len} <= space);

    // grant is only non-zero in XFER, so rdy follows it directly.
    assign rq0.rdy  = grant[0];
    assign rq1.rdy  = grant[1];
    assign rq0.rej  = rej0;
    assign rq1.rej  = rej1;

    assign acc      = (grant[0] & rq0.vld) | (grant[1] & rq1.vld);
    assign sel_data = grant[1] ? rq1.data : rq0.data;
    assign sel_eop  = grant[1] ? rq1.eop  : rq0.eop;

    // Arbitration FSM with registered grant, write strobe, error flags and packet counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            scnt       <= '0;
            last_grant <= 1'b1;
            grant      <= 2'b00;
            rej0       <= 1'b0;
            rej1       <= 1'b0;
            fifo_wrreq <= 1'b0;
            fifo_data  <= '0;
            len_err    <= 1'b0;
            ovf_err    <= 1'b0;
            pkt_cnt0   <= '0;
            pkt_cnt1   <= '0;
        end else begin
            fifo_wrreq <= 1'b0;
            rej0       <= 1'b0;
            rej1       <= 1'b0;
            if (fifo_wrfull && fifo_wrreq) begin
                ovf_err <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Refuse a bad length once; the source drops req on seeing rej.
                    if (rq0.req && !legal0 && !rej0) begin
                        rej0    <= 1'b1;
                        len_err <= 1'b1;
                    end
                    if (rq1.req && !legal1 && !rej1) begin
                        rej1    <= 1'b1;
                        len_err <= 1'b1;
                    end
                    if (elig0 && (!elig1 || last_grant)) begin
                        grant      <= 2'b01;
                        cnt        <= rq0.len;
                        last_grant <= 1'b0;
                        state      <= ST_XFER;
                    end else if (elig1) begin
                        grant      <= 2'b10;
                        cnt        <= rq1.len;
                        last_grant <= 1'b1;
                        state      <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (acc) begin
                        fifo_wrreq <= 1'b1;
                        fifo_data  <= sel_data;
                        cnt        <= cnt - (PTR+1)'(1);
                        // The length counter, not eop, decides where the packet ends.
                        if (sel_eop != (cnt == (PTR+1)'(1))) begin
                            len_err <= 1'b1;
                        end
                        if (cnt == (PTR+1)'(1)) begin
                            state <= ST_SETTLE;
                            grant <= 2'b00;
                            scnt  <= '0;
                            if (grant[0]) begin
                                pkt_cnt0 <= pkt_cnt0 + 16'd1;
                            end else begin
                                pkt_cnt1 <= pkt_cnt1 + 16'd1;
                            end
                        end
                    end
                end
                ST_SETTLE: begin
                    // Give wrusedw time to account for the final write before re-arbitrating.
                    if (scnt == SW'(SETTLE - 1)) begin
                        state <= ST_IDLE;
                    end else begin
                        scnt <= scnt + SW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fmac_ipcs_fifo_wr_arb.sv
// Randomized bench for the IPCS FIFO write arbiter against a packet-level reference model.
// Latency: model predicts every output one cycle ahead and compares at each falling edge.
// Backpressure: sources react to rdy/rej; FIFO level and full flag are randomized.
module tb_fmac_ipcs_fifo_wr_arb;
    localparam int WIDTH   = 64;
    localparam int PTR     = 9;
    localparam int MAX_LEN = 256;
    localparam int DEPTH   = 512;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fmac_ipcs_fifo_wr_arb_if #(.WIDTH(WIDTH), .PTR(PTR)) rq0_if ();
    fmac_ipcs_fifo_wr_arb_if #(.WIDTH(WIDTH), .PTR(PTR)) rq1_if ();

    logic [1:0]       s_req = '0;
    logic [1:0]       s_vld = '0;
    logic [1:0]       s_eop = '0;
    logic [PTR:0]     s_len [2];
    logic [WIDTH-1:0] s_data [2];
    logic [PTR:0]     wrusedw = '0;
    logic             wrfull = 1'b0;

    logic             fifo_wrreq;
    logic [WIDTH-1:0] fifo_data;
    logic [1:0]       grant;
    logic             len_err;
    logic             ovf_err;
    logic [15:0]      pkt_cnt0;
    logic [15:0]      pkt_cnt1;
    logic [1:0]       d_rdy;
    logic [1:0]       d_rej;

    assign rq0_if.req  = s_req[0];
    assign rq0_if.len  = s_len[0];
    assign rq0_if.vld  = s_vld[0];
    assign rq0_if.data = s_data[0];
    assign rq0_if.eop  = s_eop[0];
    assign rq1_if.req  = s_req[1];
    assign rq1_if.len  = s_len[1];
    assign rq1_if.vld  = s_vld[1];
    assign rq1_if.data = s_data[1];
    assign rq1_if.eop  = s_eop[1];
    assign d_rdy = {rq1_if.rdy, rq0_if.rdy};
    assign d_rej = {rq1_if.rej, rq0_if.rej};

    fmac_ipcs_fifo_wr_arb #(.WIDTH(WIDTH), .PTR(PTR), .MAX_LEN(MAX_LEN), .SETTLE(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .rq0          (rq0_if.slave),
        .rq1          (rq1_if.slave),
        .fifo_wrusedw (wrusedw),
        .fifo_wrfull  (wrfull),
        .fifo_wrreq   (fifo_wrreq),
        .fifo_data    (fifo_data),
        .grant        (grant),
        .len_err      (len_err),
        .ovf_err      (ovf_err),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;

    // reference model: expected outputs after the next rising edge
    logic [1:0]  e_grant;
    logic [1:0]  e_rej;
    logic        e_wr;
    logic        e_dchk;
    logic [63:0] e_data;
    logic        e_len_err;
    logic        e_ovf;
    int          e_pkt [2];
    int          rem [2];
    int          last_win;
    int          last_end;

    // source drivers
    int mode [2];
    int idx [2];
    int plen [2];
    int badpos [2];
    bit bad [2];
    bit acc_prev [2];

    // phase knobs
    bit p_ill;
    bit p_bad;
    bit p_full;
    bit p_rst;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        e_grant   = 2'b00;
        e_rej     = 2'b00;
        e_wr      = 1'b0;
        e_dchk    = 1'b1;
        e_data    = '0;
        e_len_err = 1'b0;
        e_ovf     = 1'b0;
        e_pkt     = '{0, 0};
        rem       = '{0, 0};
        last_win  = 1;
        last_end  = -100;
    endtask

    task automatic compare_all();
        check_val("grant",    64'(grant),        64'(e_grant));
        check_val("rdy0",     64'(d_rdy[0]),     64'(e_grant[0]));
        check_val("rdy1",     64'(d_rdy[1]),     64'(e_grant[1]));
        check_val("rej0",     64'(d_rej[0]),     64'(e_rej[0]));
        check_val("rej1",     64'(d_rej[1]),     64'(e_rej[1]));
        check_val("wrreq",    64'(fifo_wrreq),   64'(e_wr));
        if (e_dchk) check_val("wrdata", fifo_data, e_data);
        check_val("len_err",  64'(len_err),      64'(e_len_err));
        check_val("ovf_err",  64'(ovf_err),      64'(e_ovf));
        check_val("pkt_cnt0", 64'(pkt_cnt0),     64'(e_pkt[0] & 32'hFFFF));
        check_val("pkt_cnt1", 64'(pkt_cnt1),     64'(e_pkt[1] & 32'hFFFF));
    endtask

    task automatic pick_len(output int len);
        if (p_ill && $urandom_range(0, 5) == 0) begin
            case ($urandom_range(0, 2))
                0:       len = 0;
                1:       len = MAX_LEN + 1;
                default: len = $urandom_range(MAX_LEN + 2, 1023);
            endcase
        end else if ($urandom_range(0, 9) == 0) begin
            len = $urandom_range(100, MAX_LEN);
        end else begin
            len = $urandom_range(1, 10);
        end
    endtask

    task automatic drive(input bit force_rst);
        int len;
        reset = force_rst || (p_rst && $urandom_range(0, 299) == 0);
        if ($urandom_range(0, 29) == 0) begin
            case ($urandom_range(0, 3))
                0:       wrusedw = '0;
                1:       wrusedw = (PTR+1)'(500);
                2:       wrusedw = (PTR+1)'(496);
                default: wrusedw = (PTR+1)'($urandom_range(0, DEPTH));
            endcase
        end
        wrfull = p_full && ($urandom_range(0, 7) == 0);
        for (int s = 0; s < 2; s++) begin
            if (reset) begin
                mode[s] = 0; s_req[s] = 1'b0; s_vld[s] = 1'b0; s_eop[s] = 1'b0; acc_prev[s] = 1'b0;
            end else begin
                if (mode[s] == 0) begin
                    if ($urandom_range(0, 3) == 0) begin
                        pick_len(len);
                        s_len[s] = (PTR+1)'(len);
                        s_req[s] = 1'b1;
                        mode[s]  = 1;
                    end
                end else if (mode[s] == 1) begin
                    if (d_rej[s]) begin
                        s_req[s] = 1'b0;
                        mode[s]  = 0;
                    end else if (d_rdy[s]) begin
                        mode[s]     = 2;
                        idx[s]      = 0;
                        plen[s]     = int'(s_len[s]);
                        bad[s]      = p_bad && ($urandom_range(0, 3) == 0);
                        badpos[s]   = $urandom_range(0, plen[s] - 1);
                        acc_prev[s] = 1'b0;
                    end
                end
                if (mode[s] == 2) begin
                    if (acc_prev[s]) idx[s]++;
                    if (idx[s] >= plen[s]) begin
                        mode[s] = 0; s_req[s] = 1'b0; s_vld[s] = 1'b0; s_eop[s] = 1'b0; acc_prev[s] = 1'b0;
                    end else begin
                        if (acc_prev[s] || !s_vld[s]) s_data[s] = {$urandom, $urandom};
                        s_vld[s]    = ($urandom_range(0, 3) != 0);
                        s_eop[s]    = (idx[s] == plen[s] - 1) ^ (bad[s] && idx[s] == badpos[s]);
                        acc_prev[s] = d_rdy[s] && s_vld[s];
                    end
                end
            end
        end
    endtask

    // Packet-level prediction: words accepted on the granted source go to the FIFO in order,
    // the arbiter is free again three cycles after a packet's last word, ties alternate.
    task automatic predict(input bit cur_wr);
        logic [1:0] ng;
        bit nwr;
        bit legal;
        bit elig [2];
        int w;
        if (reset) begin
            model_reset();
            return;
        end
        ng    = e_grant;
        nwr   = 1'b0;
        e_rej = 2'b00;
        if (wrfull && cur_wr) e_ovf = 1'b1;
        for (int s = 0; s < 2; s++) begin
            if (e_grant[s] && s_vld[s]) begin
                nwr    = 1'b1;
                e_data = s_data[s];
                if (s_eop[s] != (rem[s] == 1)) e_len_err = 1'b1;
                rem[s]--;
                if (rem[s] == 0) begin
                    ng = 2'b00;
                    e_pkt[s]++;
                    last_end = cyc;
                end
            end
        end
        if (e_grant == 2'b00 && cyc >= last_end + 3) begin
            for (int s = 0; s < 2; s++) begin
                legal = (int'(s_len[s]) >= 1) && (int'(s_len[s]) <= MAX_LEN);
                if (s_req[s] && !legal) begin
                    e_rej[s]  = 1'b1;
                    e_len_err = 1'b1;
                end
                elig[s] = s_req[s] && legal && (int'(s_len[s]) <= DEPTH - int'(wrusedw));
            end
            if (elig[0] && elig[1]) w = 1 - last_win;
            else if (elig[0])       w = 0;
            else if (elig[1])       w = 1;
            else                    w = -1;
            if (w >= 0) begin
                ng       = 2'b00;
                ng[w]    = 1'b1;
                rem[w]   = int'(s_len[w]);
                last_win = w;
            end
        end
        e_grant = ng;
        e_wr    = nwr;
        e_dchk  = nwr;
    endtask

    initial begin
        bit cur_wr;
        s_len  = '{'0, '0};
        s_data = '{'0, '0};
        mode   = '{0, 0};
        idx    = '{0, 0};
        plen   = '{0, 0};
        badpos = '{0, 0};
        bad    = '{0, 0};
        acc_prev = '{0, 0};
        model_reset();
        for (int ph = 0; ph < 5; ph++) begin
            p_ill  = (ph == 1) || (ph == 4);
            p_bad  = (ph == 2) || (ph == 4);
            p_full = (ph == 3) || (ph == 4);
            p_rst  = (ph == 4);
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                compare_all();
                cur_wr = e_wr;
                drive(c < 2);
                predict(cur_wr);
                cyc++;
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
